mem_op_sequencer: RTL and testbench
===================================

// Module: mem_op_sequencer
// PURPOSE
//  Multi-cycle load/store sequencer for the execute stage's data-memory port
//  (read port 1 + write port) and the register-file write port.
//  Accepts one LD/ST/LDP/STP request at a time and expands it into per-cycle
//  memory reads/writes and register writebacks.
//  Raises busy so fetch/decode stall while the operation is in flight.
//  Replaces ad-hoc ld/ldp/stp bit chains with a single FSM.
// PARAMETERS
//  AW  15  word-address width (memory port addr is [AW:1])
//  DW  16  data width
//  RW  4   register index width
// PORTS
//  clk         in   1     clock, all state updates on rising edge
//  rst_n       in   1     asynchronous active-low reset
//  req_valid   in   1     request present; hold stable until accepted
//  req_ready   out  1     sequencer idle; request accepted when valid&ready at edge
//  req_op      in   2     00 LD, 01 ST, 10 LDP, 11 STP
//  req_addr    in   DW    byte address; bit 0 ignored
//  req_t       in   RW    target register (LD/LDP)
//  req_wd0     in   DW    store data word 0 (ST/STP)
//  req_wd1     in   DW    store data word 1 (STP)
//  mem_raddr   out  AW    read address, [AW:1]
//  mem_rdata   in   DW    read data, valid the cycle after mem_raddr
//  mem_wen     out  1     memory write enable
//  mem_waddr   out  AW    write address, [AW:1]
//  mem_wdata   out  DW    write data
//  reg_wen     out  1     register write enable
//  reg_waddr   out  RW    register write index
//  reg_wdata   out  DW    register write data (= mem_rdata)
//  busy        out  1     operation in flight (= ~req_ready)
//  op_done     out  1     one-cycle pulse in last active cycle of an op
// BEHAVIOUR
//  - States: IDLE, RD_A, RD_B, WB_B, WB_A, WR_A, WR_B. Accept latches op,
//    word addr A = req_addr[AW:1], T = req_t, D0, D1.
//  - IDLE: req_ready=1; accept -> LD/LDP: RD_A; ST/STP: WR_A.
//  - LD : RD_A mem_raddr=A -> WB_A reg_wen, reg_waddr=T, op_done -> IDLE.
//  - LDP: RD_A mem_raddr=A -> RD_B mem_raddr=A+1, reg_wen T<=rdata
//         -> WB_B reg_wen T+1<=rdata, op_done -> IDLE.
//  - ST : WR_A mem_wen, waddr=A, wdata=D0, op_done -> IDLE.
//  - STP: WR_A write A<=D0 -> WR_B write A+1<=D1, op_done -> IDLE.
//  - Latency (accept edge N = cycle 0): LD wb cycle 2; LDP wb cycles 2,3;
//    ST write cycle 1; STP writes cycles 1,2. Next accept earliest at end of
//    op_done cycle (no back-to-back overlap).
//  - A+1 wraps modulo 2^AW (0x7FFF -> 0x0000); T+1 wraps modulo 2^RW (15 -> 0).
//  - Register 0 writes are issued normally (console output handled downstream).
//  - mem_raddr outside RD_A/RD_B holds last value; mem_wen only in WR_A/WR_B;
//    reg_wen only in RD_B/WB_B/WB_A. mem_wen and reg_wen never both 1.
//  - req_valid while busy: ignored, no state change; request inputs not resampled.
//  - Reset (async, any state): state=IDLE, req_ready=1, busy=0, op_done=0,
//    mem_wen=0, reg_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0,
//    reg_waddr=0, reg_wdata=don't-care. In-flight op abandoned, partial writes
//    already done stay done.
// TESTING
//  - LD addr 0x0010, T=3, mem[8]=0xBEEF -> raddr=8 cyc1; reg_wen r3=0xBEEF cyc2, op_done cyc2.
//  - LDP addr 0x0020, T=15, mem[16]=0x1111, mem[17]=0x2222 -> r15=0x1111 cyc2, r0=0x2222 cyc3.
//  - STP addr 0xFFFE, D0=0xAAAA, D1=0x5555 -> mem[0x7FFF]=0xAAAA cyc1, mem[0x0000]=0x5555 cyc2.
//  - ST accepted then req_valid held with LD during busy -> LD accepted only after
//    op_done; busy=1 exactly during active cycles.
//  - rst_n low in RD_B of LDP -> outputs reset immediately, second reg write absent, ready=1.
//  - Odd addr 0x0011 LD -> identical to 0x0010 (bit 0 ignored).

Source files
------------

// File: rtl/mem_op_sequencer.sv
// Load/store sequencer: expands LD/ST/LDP/STP into per-cycle memory
// and register-file port activity, holding busy while in flight.
module mem_op_sequencer #(
  parameter int AW = 15,
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_addr,
  input  logic [RW-1:0] req_t,
  input  logic [DW-1:0] req_wd0,
  input  logic [DW-1:0] req_wd1,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          reg_wen,
  output logic [RW-1:0] reg_waddr,
  output logic [DW-1:0] reg_wdata,
  output logic          busy,
  output logic          op_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WB_B,
    S_WB_A,
    S_WR_A,
    S_WR_B
  } state_t;

  state_t        r_state;
  logic          r_pair;
  logic [AW-1:0] r_a;
  logic [RW-1:0] r_t;
  logic [DW-1:0] r_d1;
  logic [AW-1:0] r_raddr;
  logic          r_mem_wen;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_reg_wen;
  logic [RW-1:0] r_reg_waddr;
  logic          r_op_done;

  logic [AW-1:0] w_a;
  logic          w_accept;
  logic          w_unused;

  // Byte address in, word address out: bit 0 is dropped.
  assign w_a      = req_addr[AW:1];
  assign w_unused = req_addr[0];
  assign w_accept = req_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pair      <= 1'b0;
      r_a         <= '0;
      r_t         <= '0;
      r_d1        <= '0;
      r_raddr     <= '0;
      r_mem_wen   <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_reg_wen   <= 1'b0;
      r_reg_waddr <= '0;
      r_op_done   <= 1'b0;
    end else begin
      r_mem_wen <= 1'b0;
      r_reg_wen <= 1'b0;
      r_op_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pair <= req_op[1];
            r_a    <= w_a;
            r_t    <= req_t;
            r_d1   <= req_wd1;
            if (!req_op[0]) begin
              r_state <= S_RD_A;
              r_raddr <= w_a;
            end else begin
              r_state   <= S_WR_A;
              r_mem_wen <= 1'b1;
              r_waddr   <= w_a;
              r_wdata   <= req_wd0;
              r_op_done <= ~req_op[1];
            end
          end
        end
        S_RD_A: begin
          r_reg_wen   <= 1'b1;
          r_reg_waddr <= r_t;
          if (r_pair) begin
            r_state <= S_RD_B;
            r_raddr <= r_a + 1'b1;
          end else begin
            r_state   <= S_WB_A;
            r_op_done <= 1'b1;
          end
        end
        S_RD_B: begin
          r_state     <= S_WB_B;
          r_reg_wen   <= 1'b1;
          r_reg_waddr <= r_t + 1'b1;
          r_op_done   <= 1'b1;
        end
        S_WR_A: begin
          if (r_pair) begin
            r_state   <= S_WR_B;
            r_mem_wen <= 1'b1;
            r_waddr   <= r_a + 1'b1;
            r_wdata   <= r_d1;
            r_op_done <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WB_A,
        S_WB_B,
        S_WR_B: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = ~req_ready;
  assign mem_raddr = r_raddr;
  assign mem_wen   = r_mem_wen;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign reg_wen   = r_reg_wen;
  assign reg_waddr = r_reg_waddr;
  assign reg_wdata = mem_rdata;
  assign op_done   = r_op_done;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed bench for mem_op_sequencer with a 1-cycle-latency memory
// model; each scenario task checks its own cycle-by-cycle outputs.
module tb_mem_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_t = '0;
  logic [15:0] req_wd0 = '0;
  logic [15:0] req_wd1 = '0;
  logic [14:0] mem_raddr;
  logic [15:0] mem_rdata = '0;
  logic        mem_wen;
  logic [14:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        reg_wen;
  logic [3:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        busy;
  logic        op_done;

  int n_run = 0;
  int n_fail = 0;

  logic [15:0] mem [0:32767];

  mem_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_t(req_t),
    .req_wd0(req_wd0), .req_wd1(req_wd1),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .busy(busy), .op_done(op_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_raddr];
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_run++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_timeout got ready=%0b want 1", req_ready);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a,
                       input logic [3:0] t, input logic [15:0] d0,
                       input logic [15:0] d1);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op; req_addr = a; req_t = t;
    req_wd0 = d0; req_wd1 = d1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b want 1", req_ready); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_run++; if (op_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0b want 0", op_done); end
    n_run++; if (mem_wen !== 1'b0 || reg_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen got %0b/%0b want 0/0", mem_wen, reg_wen); end
    n_run++; if (mem_raddr !== 15'h0 || mem_waddr !== 15'h0) begin n_fail++; $display("FAIL rst_addr got %h/%h want 0/0", mem_raddr, mem_waddr); end
    n_run++; if (mem_wdata !== 16'h0 || reg_waddr !== 4'h0) begin n_fail++; $display("FAIL rst_data got %h/%h want 0/0", mem_wdata, reg_waddr); end
  endtask

  task automatic test_ld(input logic [15:0] a);
    wait_idle();
    issue(2'b00, a, 4'd3, 16'h0, 16'h0);
    @(negedge clk);
    n_run++; if (mem_raddr !== 15'h0008) begin n_fail++; $display("FAIL ld_raddr got %h want 0008", mem_raddr); end
    n_run++; if (busy !== 1'b1 || reg_wen !== 1'b0 || op_done !== 1'b0) begin n_fail++; $display("FAIL ld_c1 got busy=%0b wen=%0b done=%0b want 1/0/0", busy, reg_wen, op_done); end
    @(negedge clk);
    n_run++; if (reg_wen !== 1'b1 || reg_waddr !== 4'd3) begin n_fail++; $display("FAIL ld_wb got wen=%0b idx=%0d want 1/3", reg_wen, reg_waddr); end
    n_run++; if (reg_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL ld_data got %h want beef", reg_wdata); end
    n_run++; if (op_done !== 1'b1 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL ld_done got done=%0b mwen=%0b want 1/0", op_done, mem_wen); end
    @(negedge clk);
    n_run++; if (req_ready !== 1'b1 || reg_wen !== 1'b0 || op_done !== 1'b0) begin n_fail++; $display("FAIL ld_end got rdy=%0b wen=%0b done=%0b want 1/0/0", req_ready, reg_wen, op_done); end
  endtask

  task automatic test_ldp();
    wait_idle();
    issue(2'b10, 16'h0020, 4'd15, 16'h0, 16'h0);
    @(negedge clk);
    n_run++; if (mem_raddr !== 15'h0010 || reg_wen !== 1'b0) begin n_fail++; $display("FAIL ldp_c1 got raddr=%h wen=%0b want 0010/0", mem_raddr, reg_wen); end
    @(negedge clk);
    n_run++; if (mem_raddr !== 15'h0011) begin n_fail++; $display("FAIL ldp_raddr_b got %h want 0011", mem_raddr); end
    n_run++; if (reg_wen !== 1'b1 || reg_waddr !== 4'd15 || reg_wdata !== 16'h1111) begin n_fail++; $display("FAIL ldp_wb0 got wen=%0b r%0d=%h want 1 r15=1111", reg_wen, reg_waddr, reg_wdata); end
    n_run++; if (op_done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ldp_c2 got done=%0b busy=%0b want 0/1", op_done, busy); end
    @(negedge clk);
    n_run++; if (reg_wen !== 1'b1 || reg_waddr !== 4'd0 || reg_wdata !== 16'h2222) begin n_fail++; $display("FAIL ldp_wb1 got wen=%0b r%0d=%h want 1 r0=2222", reg_wen, reg_waddr, reg_wdata); end
    n_run++; if (op_done !== 1'b1) begin n_fail++; $display("FAIL ldp_done got %0b want 1", op_done); end
    @(negedge clk);
    n_run++; if (req_ready !== 1'b1 || reg_wen !== 1'b0) begin n_fail++; $display("FAIL ldp_end got rdy=%0b wen=%0b want 1/0", req_ready, reg_wen); end
  endtask

  task automatic test_stp_wrap();
    wait_idle();
    issue(2'b11, 16'hFFFE, 4'd0, 16'hAAAA, 16'h5555);
    req_addr = 16'h1234; req_wd0 = 16'hDEAD; req_wd1 = 16'hDEAD;
    @(negedge clk);
    n_run++; if (mem_wen !== 1'b1 || mem_waddr !== 15'h7FFF || mem_wdata !== 16'hAAAA) begin n_fail++; $display("FAIL stp_w0 got wen=%0b [%h]=%h want 1 [7fff]=aaaa", mem_wen, mem_waddr, mem_wdata); end
    n_run++; if (op_done !== 1'b0 || reg_wen !== 1'b0) begin n_fail++; $display("FAIL stp_c1 got done=%0b rwen=%0b want 0/0", op_done, reg_wen); end
    @(negedge clk);
    n_run++; if (mem_wen !== 1'b1 || mem_waddr !== 15'h0000 || mem_wdata !== 16'h5555) begin n_fail++; $display("FAIL stp_w1 got wen=%0b [%h]=%h want 1 [0000]=5555", mem_wen, mem_waddr, mem_wdata); end
    n_run++; if (op_done !== 1'b1) begin n_fail++; $display("FAIL stp_done got %0b want 1", op_done); end
    @(negedge clk);
    n_run++; if (mem_wen !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stp_end got wen=%0b rdy=%0b want 0/1", mem_wen, req_ready); end
    n_run++; if (mem[15'h7FFF] !== 16'hAAAA || mem[15'h0000] !== 16'h5555) begin n_fail++; $display("FAIL stp_mem got %h/%h want aaaa/5555", mem[15'h7FFF], mem[15'h0000]); end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_addr = 16'h0040;
    req_t = 4'd0; req_wd0 = 16'h1234; req_wd1 = 16'h0;
    @(posedge clk);
    #1 req_op = 2'b00; req_addr = 16'h0010; req_t = 4'd5;
    @(negedge clk);
    n_run++; if (busy !== 1'b1 || mem_wen !== 1'b1 || op_done !== 1'b1) begin n_fail++; $display("FAIL b2b_st got busy=%0b wen=%0b done=%0b want 1/1/1", busy, mem_wen, op_done); end
    n_run++; if (mem_waddr !== 15'h0020 || mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL b2b_st_data got [%h]=%h want [0020]=1234", mem_waddr, mem_wdata); end
    @(negedge clk);
    n_run++; if (busy !== 1'b0 || req_ready !== 1'b1 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got busy=%0b rdy=%0b wen=%0b want 0/1/0", busy, req_ready, mem_wen); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_run++; if (busy !== 1'b1 || mem_raddr !== 15'h0008) begin n_fail++; $display("FAIL b2b_ld_c1 got busy=%0b raddr=%h want 1/0008", busy, mem_raddr); end
    @(negedge clk);
    n_run++; if (reg_wen !== 1'b1 || reg_waddr !== 4'd5 || reg_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_ld_wb got wen=%0b r%0d=%h want 1 r5=beef", reg_wen, reg_waddr, reg_wdata); end
    @(negedge clk);
    n_run++; if (busy !== 1'b0 || mem[15'h0020] !== 16'h1234) begin n_fail++; $display("FAIL b2b_end got busy=%0b mem=%h want 0/1234", busy, mem[15'h0020]); end
  endtask

  task automatic test_reset_mid();
    int wr;
    wait_idle();
    issue(2'b10, 16'h0020, 4'd15, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    n_run++; if (reg_wen !== 1'b1 || reg_waddr !== 4'd15) begin n_fail++; $display("FAIL rmid_wb0 got wen=%0b idx=%0d want 1/15", reg_wen, reg_waddr); end
    #1 rst_n = 1'b0;
    #1;
    n_run++; if (reg_wen !== 1'b0 || op_done !== 1'b0) begin n_fail++; $display("FAIL rmid_out got wen=%0b done=%0b want 0/0", reg_wen, op_done); end
    n_run++; if (req_ready !== 1'b1 || busy !== 1'b0 || mem_raddr !== 15'h0) begin n_fail++; $display("FAIL rmid_state got rdy=%0b busy=%0b raddr=%h want 1/0/0", req_ready, busy, mem_raddr); end
    @(negedge clk);
    rst_n = 1'b1;
    wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (reg_wen === 1'b1) wr++;
    end
    n_run++; if (wr != 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after got writes=%0d rdy=%0b want 0/1", wr, req_ready); end
  endtask

  initial begin
    mem[15'h0008] = 16'hBEEF;
    mem[15'h0010] = 16'h1111;
    mem[15'h0011] = 16'h2222;
    mem[15'h7FFF] = 16'h0000;
    mem[15'h0000] = 16'h0000;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_ld(16'h0010);
    test_ld(16'h0011);
    test_ldp();
    test_stp_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
